// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response channel.
//
// Handshake: a requester raises req together with wr/wstrb/addr/wdata and
// holds all of them stable until it samples addr_ok high on a rising edge;
// addr_ok is a one-cycle pulse that completes the address phase. The data
// phase completes with a one-cycle data_ok pulse; rdata is meaningful only
// in that cycle. At most one transaction is outstanding on a channel.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  wr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  // Side that issues requests.
  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests.
  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the
// MEM-stage data access. One transaction at a time is sequenced through a
// grant cycle, an address phase and a response phase. Data wins ties unless
// fetch has lost STARVE_LIMIT consecutive contested grants.
module sram_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_bus_arbiter_if.slave    inst_if,
  sram_bus_arbiter_if.slave    data_if,
  sram_bus_arbiter_if.master   mem_if,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;     // 0 = inst, 1 = data
  logic [CNT_W-1:0]   starve_q, starve_d;

  logic               starve_full;
  logic               grant_data;
  logic               in_addr;
  logic               in_resp;
  logic               data_store;

  assign starve_full = (starve_q == CNT_W'(STARVE_LIMIT));
  // Data wins unless fetch is also waiting and has been passed over too often.
  assign grant_data  = data_if.req && !(inst_if.req && starve_full);

  // Next-state, owner and starvation counter; everything is decided in IDLE.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (inst_if.req || data_if.req) begin
          state_d = S_ADDR;
          owner_d = grant_data;
          if (grant_data && inst_if.req) begin
            starve_d = starve_full ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      S_ADDR: begin
        if (mem_if.addr_ok) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_if.data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign in_addr    = (state_q == S_ADDR);
  assign in_resp    = (state_q == S_RESP);
  assign data_store = in_addr && owner_q && data_if.wr;

  // Memory side: fields follow the owner only during the address phase;
  // fetches are always reads, and byte enables are zero on any read.
  assign mem_if.req   = in_addr;
  assign mem_if.wr    = data_store;
  assign mem_if.wstrb = data_store ? data_if.wstrb : {STRB_W{1'b0}};
  assign mem_if.addr  = !in_addr ? {ADDR_W{1'b0}} :
                        (owner_q ? data_if.addr : inst_if.addr);
  assign mem_if.wdata = (in_addr && owner_q) ? data_if.wdata : {DATA_W{1'b0}};

  // Requester side: strobes go only to the owner, only in the right phase.
  assign inst_if.addr_ok = in_addr && !owner_q && mem_if.addr_ok;
  assign data_if.addr_ok = in_addr &&  owner_q && mem_if.addr_ok;
  assign inst_if.data_ok = in_resp && !owner_q && mem_if.data_ok;
  assign data_if.data_ok = in_resp &&  owner_q && mem_if.data_ok;
  assign inst_if.rdata   = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;

  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
